// File: rtl/seg_capture.sv
// Captures a multiplexed active-low 7-segment display (4 digits) into a 16-bit hex value.
// A digit is accepted once its anode/segment pattern has been stable for STABLE_CYCLES samples.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        clr,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        err,
  output logic [1:0]  err_digit,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  localparam logic [3:0] ACC_CNT = 4'(STABLE_CYCLES - 1);

  // Returns {legal, nibble}; illegal codes return 5'h00.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h01:   r = 5'h10;
      7'h4F:   r = 5'h11;
      7'h12:   r = 5'h12;
      7'h06:   r = 5'h13;
      7'h4C:   r = 5'h14;
      7'h24:   r = 5'h15;
      7'h20:   r = 5'h16;
      7'h0F:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h04:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h60:   r = 5'h1B;
      7'h31:   r = 5'h1C;
      7'h42:   r = 5'h1D;
      7'h10:   r = 5'h1E;
      7'h38:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Returns {selectable, index}; only a single active-low anode is selectable.
  function automatic logic [2:0] an_select(input logic [3:0] a);
    logic [2:0] r;
    case (a)
      4'b1110: r = 3'b100;
      4'b1101: r = 3'b101;
      4'b1011: r = 3'b110;
      4'b0111: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  logic [3:0]  an_q, pan_q;
  logic [6:0]  seg_q, pseg_q;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  dv_q, dv_d;
  logic        err_q, err_d;
  logic [1:0]  err_digit_q, err_digit_d;
  logic        frame_q, frame_d;
  logic [3:0]  seen_q, seen_d;

  logic [2:0]  sel_s;
  logic [4:0]  dec_s;
  logic        same_s;
  logic        accept_s;
  logic [3:0]  seen_next_s;

  assign sel_s  = an_select(an_q);
  assign dec_s  = seg_decode(seg_q);
  assign same_s = (an_q == pan_q) && (seg_q == pseg_q);

  // Stability-tracking FSM; accept fires on the edge the count reaches STABLE_CYCLES.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_s[2]) begin
          state_d = S_TRACK;
          cnt_d   = 4'd1;
        end else begin
          cnt_d   = 4'd0;
        end
      end
      S_TRACK: begin
        if (!sel_s[2]) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (same_s) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == ACC_CNT) begin
            state_d  = S_HELD;
            accept_s = 1'b1;
          end else begin
            state_d  = S_TRACK;
          end
        end else begin
          cnt_d = 4'd1;
        end
      end
      S_HELD: begin
        if (!sel_s[2]) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (same_s) begin
          cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end else begin
          state_d = S_TRACK;
          cnt_d   = 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Captured-data update; clear overrides a same-cycle accept.
  always_comb begin
    value_d     = value_q;
    dv_d        = dv_q;
    err_d       = err_q;
    err_digit_d = err_digit_q;
    seen_d      = seen_q;
    frame_d     = 1'b0;
    seen_next_s = seen_q | (4'b0001 << sel_s[1:0]);
    if (clr) begin
      value_d     = 16'h0000;
      dv_d        = 4'b0000;
      err_d       = 1'b0;
      err_digit_d = 2'd0;
      seen_d      = 4'b0000;
    end else if (accept_s) begin
      if (dec_s[4]) begin
        value_d[{sel_s[1:0], 2'b00} +: 4] = dec_s[3:0];
        dv_d[sel_s[1:0]]                  = 1'b1;
      end else begin
        dv_d[sel_s[1:0]] = 1'b0;
        err_d            = 1'b1;
        err_digit_d      = sel_s[1:0];
      end
      if (seen_next_s == 4'b1111) begin
        frame_d = 1'b1;
        seen_d  = 4'b0000;
      end else begin
        seen_d  = seen_next_s;
      end
    end else begin
      seen_d = seen_q;
    end
  end

  // State and sample registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      pan_q       <= 4'b1111;
      pseg_q      <= 7'h7F;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      value_q     <= 16'h0000;
      dv_q        <= 4'b0000;
      err_q       <= 1'b0;
      err_digit_q <= 2'd0;
      frame_q     <= 1'b0;
      seen_q      <= 4'b0000;
    end else begin
      an_q        <= an;
      seg_q       <= seg;
      pan_q       <= an_q;
      pseg_q      <= seg_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      dv_q        <= dv_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
      frame_q     <= frame_d;
      seen_q      <= seen_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = dv_q;
  assign err         = err_q;
  assign err_digit   = err_digit_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed testbench for seg_capture with hand-computed expectations.
module tb_seg_capture;

  logic        clk;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        clr;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        err;
  logic [1:0]  err_digit;
  logic        frame_done;

  int n_chk;
  int n_pass;

  seg_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .clr         (clr),
    .value       (value),
    .digit_valid (digit_valid),
    .err         (err),
    .err_digit   (err_digit),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_chk++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] v, input logic [3:0] dv,
                         input logic e, input logic [1:0] ed, input logic fd);
    chk({tag, ".value"}, value, v);
    chk({tag, ".dv"}, {12'h000, digit_valid}, {12'h000, dv});
    chk({tag, ".err"}, {15'h0000, err}, {15'h0000, e});
    chk({tag, ".err_digit"}, {14'h0000, err_digit}, {14'h0000, ed});
    chk({tag, ".frame"}, {15'h0000, frame_done}, {15'h0000, fd});
  endtask

  logic [3:0] an_tab  [4];
  logic [6:0] seg_tab [4];
  int fcount;
  int fat;

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_tab = '{7'h06, 7'h4C, 7'h24, 7'h0F};
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    clr   = 1'b0;

    step(2);
    chk_all("reset", 16'h0000, 4'h0, 1'b0, 2'd0, 1'b0);

    // Single digit: accept exactly 4 edges after the first edge sampling new inputs.
    rst_n = 1'b1;
    an    = 4'hE;
    seg   = 7'h12;
    step(4);
    chk("lat.before", {12'h000, digit_valid}, 16'h0000);
    step(1);
    chk("lat.dv", {12'h000, digit_valid}, 16'h0001);
    chk("lat.value", value, 16'h0002);
    step(1);
    chk("lat.hold", value, 16'h0002);
    chk("lat.noframe", {15'h0000, frame_done}, 16'h0000);

    an = 4'hF;
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk_all("clr1", 16'h0000, 4'h0, 1'b0, 2'd0, 1'b0);

    // Four-digit scan; frame pulse exactly once, right after the fourth accept.
    fcount = 0;
    fat    = -1;
    for (int d = 0; d < 4; d++) begin
      an  = an_tab[d];
      seg = seg_tab[d];
      for (int c = 0; c < 5; c++) begin
        step(1);
        if (frame_done) begin
          fcount++;
          fat = d * 5 + c + 1;
        end
      end
    end
    an = 4'hF;
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (frame_done) fcount++;
    end
    chk("scan.value", value, 16'h7543);
    chk("scan.dv", {12'h000, digit_valid}, 16'h000F);
    chk("scan.fcount", 16'(fcount), 16'd1);
    chk("scan.fat", 16'(fat), 16'd20);

    // Illegal code on digit 2.
    an  = 4'hB;
    seg = 7'h7F;
    step(4);
    chk("ill.before", {15'h0000, err}, 16'h0000);
    step(1);
    chk_all("ill", 16'h7543, 4'b1011, 1'b1, 2'd2, 1'b0);

    // Unstable toggling and non-selectable anodes never accept.
    an = 4'hE;
    for (int r = 0; r < 3; r++) begin
      seg = 7'h12;
      step(2);
      seg = 7'h06;
      step(2);
    end
    chk("tog.value", value, 16'h7543);
    chk("tog.dv", {12'h000, digit_valid}, 16'h000B);
    an = 4'hF;
    step(6);
    an  = 4'hC;
    seg = 7'h12;
    step(6);
    chk("nsel.value", value, 16'h7543);
    chk("nsel.dv", {12'h000, digit_valid}, 16'h000B);

    // Clear on the accept edge discards the accept; no re-accept while held.
    an  = 4'hE;
    seg = 7'h4F;
    step(4);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk_all("clracc", 16'h0000, 4'h0, 1'b0, 2'd0, 1'b0);
    step(2);
    chk("clracc.held", {12'h000, digit_valid}, 16'h0000);

    // Set error state, then reset during TRACK.
    an  = 4'hD;
    seg = 7'h7F;
    step(5);
    chk("err1.err", {15'h0000, err}, 16'h0001);
    chk("err1.digit", {14'h0000, err_digit}, 16'h0001);
    an  = 4'hE;
    seg = 7'h24;
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk_all("rstmid", 16'h0000, 4'h0, 1'b0, 2'd0, 1'b0);
    step(4);
    chk("rst.window", {12'h000, digit_valid}, 16'h0000);
    step(1);
    chk("rst.dv", {12'h000, digit_valid}, 16'h0001);
    chk("rst.value", value, 16'h0005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, legal 2..15: consecutive identical samples required before a digit is accepted.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 an  input  4  digit anode enables, active-low; an[i]=0 selects digit i (i=0 rightmost).
REQ-005 seg  input  7  segment lines, active-low (0 = lit), bit6=a, bit5=b ... bit0=g.
REQ-006 clr  input  1  synchronous clear of captured data.
REQ-007 value  output  16  decoded hex value; digit i in value[4i+3:4i].
REQ-008 digit_valid  output  4  digit_valid[i]=1 when nibble i holds a decoded valid code.
REQ-009 err  output  1  sticky; an accepted pattern was not a legal code.
REQ-010 err_digit  output  2  index of the most recent illegal digit.
REQ-011 frame_done  output  1  one-cycle pulse; all four digits accepted since last frame.

Function
REQ-012 an and seg SHALL be registered once (sample register) before any use.
REQ-013 Legal seg codes (hex) -> nibble: 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7, 00->8, 04->9, 08->A, 60->B, 31->C, 42->D, 10->E, 38->F; all other codes are illegal.
REQ-014 A sample is selectable when registered an has exactly one bit at 0; all-ones (blank) or multiple zeros are non-selectable.
REQ-015 FSM states: IDLE (no selectable sample), TRACK (counting stability), HELD (digit accepted, waiting for change).
REQ-016 IDLE -> TRACK when sample selectable, stability count set to 1.
REQ-017 TRACK: sample identical (an and seg) to previous and selectable -> count+1; differs but selectable -> count=1, stay TRACK; non-selectable -> IDLE, count=0.
REQ-018 TRACK -> HELD on the edge at which count would reach STABLE_CYCLES; digit accepted on that same edge.
REQ-019 HELD: identical sample -> stay, no re-accept; differing selectable sample -> TRACK, count=1; non-selectable -> IDLE.
REQ-020 Latency: inputs stable from sampling edge E0 -> outputs update at edge E0+STABLE_CYCLES-1 after registration, i.e. STABLE_CYCLES edges after inputs first change.
REQ-021 Accept, legal code: value nibble i <= decoded nibble, digit_valid[i] <= 1, seen[i] <= 1.
REQ-022 Accept, illegal code: nibble i unchanged, digit_valid[i] <= 0, err <= 1, err_digit <= i, seen[i] <= 1.
REQ-023 When an accept makes seen all ones, frame_done SHALL pulse high for exactly the following cycle and seen SHALL clear to 0000 on the same edge.
REQ-024 Re-accepting an already-seen digit SHALL update its nibble but not advance the frame.
REQ-025 clr=1: value=0, digit_valid=0, err=0, err_digit=0, seen=0, frame_done=0; FSM and stability count unaffected; clr wins over a same-cycle accept (accept discarded, FSM still goes HELD).
REQ-026 Stability counter SHALL saturate and never wrap while HELD.

Reset
REQ-027 rst_n=0 at a clock edge: value=0000, digit_valid=0000, err=0, err_digit=0, frame_done=0, seen=0000, sample register an=1111/seg=7F, FSM=IDLE, count=0.
REQ-028 Reset mid-TRACK or HELD SHALL discard the pending digit; no accept occurs on the reset edge.
REQ-029 After rst_n rises, the first accept requires a full STABLE_CYCLES stability window.

Verification
REQ-030 STABLE_CYCLES=4, an=1110, seg=12 held 6 cycles -> value[3:0]=2, digit_valid=0001 exactly 4 edges after the first edge seeing the new inputs; single accept only.
REQ-031 Scan an=1110/1101/1011/0111 with seg 06/4C/24/0F, 5 cycles each -> value=0x7543, digit_valid=1111, frame_done high for exactly one cycle after the fourth accept.
REQ-032 an=1011, seg=7F held 5 cycles -> err=1, err_digit=2, digit_valid[2]=0, value[11:8] unchanged.
REQ-033 seg toggles 12/06 every 2 cycles with an=1110 -> no accept, value and digit_valid unchanged; an=1111 or an=1100 held -> no accept.
REQ-034 clr asserted on the accept edge -> all outputs 0 next cycle; rst_n low for one edge during TRACK -> all outputs at reset values, no accept.
